// File: rtl/ultrasonic_ranger_mc.sv
// ultrasonic_ranger_mc: N-channel HC-SR04-style range sequencer.
// Round-robin per channel: trigger pulse, time the echo width in clk cycles,
// publish the result with timeout and near-object flags.
// Optional feature: define RANGER_HYST_EN to add hysteresis to the near flag.
module ultrasonic_ranger_mc #(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned TRIG_CYC     = 500,
  parameter int unsigned RISE_TO_CYC  = 50_000,
  parameter int unsigned ECHO_MAX_CYC = 1_000_000,
  parameter int unsigned GAP_CYC      = 500_000,
  parameter int unsigned THRESH       = 29_000,
  parameter int unsigned HYST         = 2_900
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  input  logic [N_CH-1:0]                           echo,
  output logic [N_CH-1:0]                           trig,
  output logic [N_CH*CNT_W-1:0]                     dist_flat,
  output logic                                      valid,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] valid_ch,
  output logic [N_CH-1:0]                           timeout,
  output logic [N_CH-1:0]                           near
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

`ifdef RANGER_HYST_EN
  localparam logic HYST_ON = 1'b1;
`else
  localparam logic HYST_ON = 1'b0;
`endif

  // With a zero band the set/clear/hold rule collapses to near = (dist < THRESH).
  localparam int unsigned HYST_EFF = HYST_ON ? HYST : 0;
  localparam int unsigned CLR_AT   = THRESH + HYST_EFF;

  localparam int unsigned M0   = (TRIG_CYC > RISE_TO_CYC) ? TRIG_CYC : RISE_TO_CYC;
  localparam int unsigned M1   = (ECHO_MAX_CYC > GAP_CYC) ? ECHO_MAX_CYC : GAP_CYC;
  localparam int unsigned M2   = (M0 > M1) ? M0 : M1;
  localparam int unsigned MAXV = (M2 > CLR_AT) ? M2 : CLR_AT;
  localparam int unsigned CTR_W = $clog2(MAXV + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  state_t                       state_q;
  logic [CTR_W-1:0]             cnt_q;
  logic [CH_W-1:0]              ch_q;
  logic [CH_W-1:0]              ch_nxt;
  logic [N_CH-1:0]              echo_s1_q;
  logic [N_CH-1:0]              echo_s2_q;
  logic [N_CH-1:0]              echo_s3_q;
  logic [N_CH-1:0]              trig_q;
  logic [N_CH-1:0][CNT_W-1:0]   dist_q;
  logic                         valid_q;
  logic [CH_W-1:0]              valid_ch_q;
  logic [N_CH-1:0]              timeout_q;
  logic [N_CH-1:0]              near_q;

  logic echo_now;
  logic echo_rise;
  logic pub_meas;
  logic pub_to;
  logic near_nxt;

  assign trig      = trig_q;
  assign dist_flat = dist_q;
  assign valid     = valid_q;
  assign valid_ch  = valid_ch_q;
  assign timeout   = timeout_q;
  assign near      = near_q;

  // Two-flop synchroniser per channel plus one extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_s1_q <= '0;
      echo_s2_q <= '0;
      echo_s3_q <= '0;
    end else begin
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
    end
  end

  // Selected-channel echo view, publish conditions and next near value.
  always_comb begin
    echo_now  = echo_s2_q[ch_q];
    echo_rise = echo_now & ~echo_s3_q[ch_q];
    ch_nxt    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
    pub_meas  = (state_q == S_MEASURE) && !echo_now;
    pub_to    = ((state_q == S_WAIT_RISE) && !echo_rise &&
                 (cnt_q == CTR_W'(RISE_TO_CYC - 1))) ||
                ((state_q == S_MEASURE) && echo_now &&
                 (cnt_q == CTR_W'(ECHO_MAX_CYC - 1)));
    if (cnt_q < CTR_W'(THRESH)) begin
      near_nxt = 1'b1;
    end else if (cnt_q >= CTR_W'(CLR_AT)) begin
      near_nxt = 1'b0;
    end else begin
      near_nxt = near_q[ch_q];
    end
  end

  // Measurement sequencer: trigger, wait for rise, time echo, hold off, next channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      trig_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (en) begin
            state_q      <= S_TRIG;
            trig_q[ch_q] <= 1'b1;
          end
        end
        S_TRIG: begin
          if (cnt_q == CTR_W'(TRIG_CYC - 1)) begin
            trig_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_WAIT_RISE;
          end else begin
            cnt_q <= cnt_q + CTR_W'(1);
          end
        end
        S_WAIT_RISE: begin
          if (echo_rise) begin
            // The detecting cycle is the first high cycle of the echo.
            cnt_q   <= CTR_W'(1);
            state_q <= S_MEASURE;
          end else if (pub_to) begin
            cnt_q   <= '0;
            state_q <= S_HOLDOFF;
          end else begin
            cnt_q <= cnt_q + CTR_W'(1);
          end
        end
        S_MEASURE: begin
          if (pub_meas || pub_to) begin
            cnt_q   <= '0;
            state_q <= S_HOLDOFF;
          end else begin
            cnt_q <= cnt_q + CTR_W'(1);
          end
        end
        S_HOLDOFF: begin
          if (cnt_q == CTR_W'(GAP_CYC - 1)) begin
            cnt_q <= '0;
            ch_q  <= ch_nxt;
            if (en) begin
              state_q        <= S_TRIG;
              trig_q[ch_nxt] <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CTR_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          trig_q  <= '0;
        end
      endcase
    end
  end

  // Result registers: only the active channel is updated on a publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      dist_q     <= '0;
      valid_q    <= 1'b0;
      valid_ch_q <= '0;
      timeout_q  <= '0;
      near_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      if (pub_to) begin
        dist_q[ch_q]    <= CNT_W'(ECHO_MAX_CYC);
        timeout_q[ch_q] <= 1'b1;
        near_q[ch_q]    <= 1'b0;
        valid_q         <= 1'b1;
        valid_ch_q      <= ch_q;
      end else if (pub_meas) begin
        dist_q[ch_q]    <= CNT_W'(cnt_q);
        timeout_q[ch_q] <= 1'b0;
        near_q[ch_q]    <= near_nxt;
        valid_q         <= 1'b1;
        valid_ch_q      <= ch_q;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Directed testbench for ultrasonic_ranger_mc (N_CH=2, short timing parameters).
// Honours RANGER_HYST_EN for the near-flag expectations.
module tb_ultrasonic_ranger_mc;

  localparam int N_CH   = 2;
  localparam int CNT_W  = 20;

`ifdef RANGER_HYST_EN
  localparam logic EXP_NEAR_310 = 1'b1;
`else
  localparam logic EXP_NEAR_310 = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic [N_CH-1:0]        echo;
  logic [N_CH-1:0]        trig;
  logic [N_CH*CNT_W-1:0]  dist_flat;
  logic                   valid;
  logic [0:0]             valid_ch;
  logic [N_CH-1:0]        timeout;
  logic [N_CH-1:0]        near;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  ultrasonic_ranger_mc #(
    .N_CH(2), .CNT_W(20), .TRIG_CYC(5), .RISE_TO_CYC(100), .ECHO_MAX_CYC(1000),
    .GAP_CYC(50), .THRESH(300), .HYST(20)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(trig), .dist_flat(dist_flat),
    .valid(valid), .valid_ch(valid_ch), .timeout(timeout), .near(near)
  );

  function automatic logic [CNT_W-1:0] dist_of(input int ch);
    return dist_flat[ch*CNT_W +: CNT_W];
  endfunction

  // Waits for trig[ch], times it, drives an echo of 'width' cycles after trig falls
  // (0 = drive low, <0 = leave echo untouched) and returns when valid is seen.
  task automatic measure(input int ch, input int width, input bit drop_en,
                         output bit ok, output int wait_cyc, output int trig_len,
                         output bit other_trig, output int k);
    ok = 1'b0; wait_cyc = 0; trig_len = 0; other_trig = 1'b0; k = 0;
    while (trig[ch] !== 1'b1 && wait_cyc < 400) begin
      @(negedge clk); wait_cyc++;
    end
    if (trig[ch] !== 1'b1) return;
    if (drop_en) en = 1'b0;
    while (trig[ch] === 1'b1 && trig_len < 20) begin
      if (trig[1-ch] !== 1'b0) other_trig = 1'b1;
      @(negedge clk); trig_len++;
    end
    if (trig[ch] !== 1'b0) return;
    if (width > 0) echo[ch] = 1'b1;
    else if (width == 0) echo[ch] = 1'b0;
    while (valid !== 1'b1 && k < 2100) begin
      @(negedge clk); k++;
      if (width > 0 && k == width) echo[ch] = 1'b0;
    end
    ok = (valid === 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; echo = '0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({trig, valid, valid_ch, timeout, near} !== '0 || dist_flat !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: trig=%b valid=%b valid_ch=%b timeout=%b near=%b dist=%h, expected all 0",
               trig, valid, valid_ch, timeout, near, dist_flat);
    end
    rst = 1'b0;
  endtask

  task automatic test_trig_and_measure;
    bit ok, ot; int w, tl, k;
    measure(0, 400, 1'b0, ok, w, tl, ot, k);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ch0_valid_seen: got %0d expected 1", ok); end
    n_checks++; if (tl != 5) begin n_fail++; $display("FAIL ch0_trig_len: got %0d expected 5", tl); end
    n_checks++; if (ot !== 1'b0) begin n_fail++; $display("FAIL ch0_trig1_idle: got %0d expected 0", ot); end
    n_checks++; if (valid_ch !== 1'b0) begin n_fail++; $display("FAIL ch0_valid_ch: got %0d expected 0", valid_ch); end
    n_checks++; if (dist_of(0) !== 20'd400) begin n_fail++; $display("FAIL ch0_dist400: got %0d expected 400", dist_of(0)); end
    n_checks++; if (near[0] !== 1'b0 || timeout[0] !== 1'b0) begin n_fail++; $display("FAIL ch0_flags: near=%b timeout=%b expected 0 0", near[0], timeout[0]); end
    n_checks++; if (dist_of(1) !== 20'd0) begin n_fail++; $display("FAIL ch1_untouched: got %0d expected 0", dist_of(1)); end
  endtask

  task automatic test_second_channel;
    bit ok, ot; int w, tl, k;
    measure(1, 200, 1'b0, ok, w, tl, ot, k);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ch1_valid_seen: got %0d expected 1", ok); end
    n_checks++; if (w != 50) begin n_fail++; $display("FAIL ch1_gap: got %0d expected 50", w); end
    n_checks++; if (tl != 5 || ot !== 1'b0) begin n_fail++; $display("FAIL ch1_trig: len=%0d other=%0d expected 5 0", tl, ot); end
    n_checks++; if (valid_ch !== 1'b1) begin n_fail++; $display("FAIL ch1_valid_ch: got %0d expected 1", valid_ch); end
    n_checks++; if (dist_of(1) !== 20'd200) begin n_fail++; $display("FAIL ch1_dist200: got %0d expected 200", dist_of(1)); end
    n_checks++; if (near[1] !== 1'b1 || timeout[1] !== 1'b0) begin n_fail++; $display("FAIL ch1_flags: near=%b timeout=%b expected 1 0", near[1], timeout[1]); end
    n_checks++; if (dist_of(0) !== 20'd400) begin n_fail++; $display("FAIL ch0_hold: got %0d expected 400", dist_of(0)); end
  endtask

  task automatic test_rise_timeout;
    bit ok, ot; int w, tl, k;
    measure(0, 0, 1'b0, ok, w, tl, ot, k);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rto_valid_seen: got %0d expected 1", ok); end
    n_checks++; if (w != 50) begin n_fail++; $display("FAIL rto_gap: got %0d expected 50", w); end
    n_checks++; if (k != 100) begin n_fail++; $display("FAIL rto_latency: got %0d expected 100", k); end
    n_checks++; if (dist_of(0) !== 20'd1000) begin n_fail++; $display("FAIL rto_dist: got %0d expected 1000", dist_of(0)); end
    n_checks++; if (timeout[0] !== 1'b1 || near[0] !== 1'b0) begin n_fail++; $display("FAIL rto_flags: timeout=%b near=%b expected 1 0", timeout[0], near[0]); end
    n_checks++; if (dist_of(1) !== 20'd200 || near[1] !== 1'b1) begin n_fail++; $display("FAIL rto_ch1_hold: dist=%0d near=%b expected 200 1", dist_of(1), near[1]); end
  endtask

  task automatic test_echo_stuck;
    bit ok, ot; int w, tl, k;
    measure(1, 5000, 1'b0, ok, w, tl, ot, k);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stuck_valid_seen: got %0d expected 1", ok); end
    n_checks++; if (k != 1002) begin n_fail++; $display("FAIL stuck_latency: got %0d expected 1002", k); end
    n_checks++; if (dist_of(1) !== 20'd1000 || valid_ch !== 1'b1) begin n_fail++; $display("FAIL stuck_dist: dist=%0d ch=%0d expected 1000 1", dist_of(1), valid_ch); end
    n_checks++; if (timeout[1] !== 1'b1 || near[1] !== 1'b0) begin n_fail++; $display("FAIL stuck_flags: timeout=%b near=%b expected 1 0", timeout[1], near[1]); end
    measure(0, 0, 1'b0, ok, w, tl, ot, k);
    n_checks++; if (ok !== 1'b1 || w != 50) begin n_fail++; $display("FAIL stuck_next_trig: ok=%0d gap=%0d expected 1 50", ok, w); end
    measure(1, -1, 1'b0, ok, w, tl, ot, k);
    n_checks++; if (ok !== 1'b1 || k != 100) begin n_fail++; $display("FAIL already_high_no_rise: ok=%0d latency=%0d expected 1 100", ok, k); end
    n_checks++; if (dist_of(1) !== 20'd1000 || timeout[1] !== 1'b1) begin n_fail++; $display("FAIL already_high_result: dist=%0d timeout=%b expected 1000 1", dist_of(1), timeout[1]); end
    echo[1] = 1'b0;
  endtask

  task automatic test_hysteresis;
    bit ok, ot; int w, tl, k;
    measure(0, 290, 1'b0, ok, w, tl, ot, k);
    n_checks++; if (dist_of(0) !== 20'd290 || near[0] !== 1'b1 || timeout[0] !== 1'b0) begin n_fail++; $display("FAIL hyst_290: dist=%0d near=%b timeout=%b expected 290 1 0", dist_of(0), near[0], timeout[0]); end
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle: got %b expected 0", valid); end
    measure(1, 500, 1'b0, ok, w, tl, ot, k);
    measure(0, 310, 1'b0, ok, w, tl, ot, k);
    n_checks++; if (dist_of(0) !== 20'd310 || near[0] !== EXP_NEAR_310) begin n_fail++; $display("FAIL hyst_310: dist=%0d near=%b expected 310 %b", dist_of(0), near[0], EXP_NEAR_310); end
    measure(1, 500, 1'b0, ok, w, tl, ot, k);
    n_checks++; if (dist_of(1) !== 20'd500 || near[1] !== 1'b0) begin n_fail++; $display("FAIL ch1_500: dist=%0d near=%b expected 500 0", dist_of(1), near[1]); end
    measure(0, 330, 1'b0, ok, w, tl, ot, k);
    n_checks++; if (dist_of(0) !== 20'd330 || near[0] !== 1'b0) begin n_fail++; $display("FAIL hyst_330: dist=%0d near=%b expected 330 0", dist_of(0), near[0]); end
  endtask

  task automatic test_reset_mid;
    bit ok, ot; int w, tl, k;
    w = 0;
    while (trig[1] !== 1'b1 && w < 400) begin @(negedge clk); w++; end
    while (trig[1] === 1'b1 && w < 420) begin @(negedge clk); w++; end
    n_checks++; if (trig[1] !== 1'b0 || w >= 400) begin n_fail++; $display("FAIL rstmid_trig1_seen: waited=%0d expected < 400", w); end
    echo[1] = 1'b1;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (trig !== 2'b00 || valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_trig_drop: trig=%b valid=%b expected 00 0", trig, valid); end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({trig, valid, valid_ch, timeout, near} !== '0 || dist_flat !== '0) begin
      n_fail++;
      $display("FAIL rstmid_cleared: trig=%b valid=%b timeout=%b near=%b dist=%h expected all 0",
               trig, valid, timeout, near, dist_flat);
    end
    echo[1] = 1'b0;
    rst = 1'b0;
    measure(0, 150, 1'b0, ok, w, tl, ot, k);
    n_checks++; if (ok !== 1'b1 || w != 1 || tl != 5) begin n_fail++; $display("FAIL rstmid_restart_ch0: ok=%0d wait=%0d len=%0d expected 1 1 5", ok, w, tl); end
    n_checks++; if (dist_of(0) !== 20'd150 || dist_of(1) !== 20'd0 || near !== 2'b01 || timeout !== 2'b00) begin n_fail++; $display("FAIL rstmid_result: dist0=%0d dist1=%0d near=%b timeout=%b expected 150 0 01 00", dist_of(0), dist_of(1), near, timeout); end
  endtask

  task automatic test_en_low;
    bit ok, ot, any_trig; int w, tl, k;
    measure(1, 100, 1'b1, ok, w, tl, ot, k);
    n_checks++; if (ok !== 1'b1 || dist_of(1) !== 20'd100 || valid_ch !== 1'b1) begin n_fail++; $display("FAIL enlow_completes: ok=%0d dist1=%0d ch=%0d expected 1 100 1", ok, dist_of(1), valid_ch); end
    any_trig = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (trig !== 2'b00) any_trig = 1'b1;
    end
    n_checks++; if (any_trig !== 1'b0) begin n_fail++; $display("FAIL enlow_idle: trig activity=%0d expected 0", any_trig); end
    en = 1'b1;
    measure(0, 250, 1'b0, ok, w, tl, ot, k);
    n_checks++; if (ok !== 1'b1 || w != 1 || dist_of(0) !== 20'd250 || near[0] !== 1'b1) begin n_fail++; $display("FAIL enlow_resume_ch0: ok=%0d wait=%0d dist0=%0d near0=%b expected 1 1 250 1", ok, w, dist_of(0), near[0]); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; echo = '0;
    test_reset();
    test_trig_and_measure();
    test_second_channel();
    test_rise_timeout();
    test_echo_stuck();
    test_hysteresis();
    test_reset_mid();
    test_en_low();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
